// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and reset-value helper for the scoreboarded register file.
// Latency: n/a (compile-time constants and a pure function).
// Backpressure: n/a.
package reg_file_sb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  // Reset value of bit bit_pos of entry idx: one-hot at (idx mod data_w), or zero.
  function automatic logic rst_bit(input int init_onehot, input int idx,
                                   input int bit_pos, input int data_w);
    return (init_onehot != 0) && (bit_pos == (idx % data_w));
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-entry busy bits: reserve sets, write releases, set wins on collision.
// Latency: busy registered (1 cycle); rd_stall is combinational.
// Backpressure: rd_stall refuses a read touching a busy entry not written this cycle.
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ZERO_R0 = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  input  logic                   rd_req,
  input  logic [ADDR_W-1:0]      rd_addr1,
  input  logic [ADDR_W-1:0]      rd_addr2,
  output logic [(2**ADDR_W)-1:0] busy,
  output logic                   rd_stall
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_nxt;
  logic             blk1;
  logic             blk2;

  // Next busy: release on write first, then reserve so a same-cycle set wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_en)  busy_nxt[wr_addr]  = 1'b0;
    if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
    if (ZERO_R0 != 0) busy_nxt[0] = 1'b0;
  end

  // Busy register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  // A busy entry is readable only when its producer writes it this very cycle.
  always_comb begin
    blk1     = busy[rd_addr1] && !(wr_en && (wr_addr == rd_addr1));
    blk2     = busy[rd_addr2] && !(wr_en && (wr_addr == rd_addr2));
    rd_stall = rd_req && (blk1 || blk2);
  end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with write-first bypass and busy scoreboard.
// Latency: 1 cycle from accepted rd_req to rd_valid; full throughput.
// Backpressure: rd_stall refuses reads of reserved entries; refused reads hold data.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int ZERO_R0     = 0,
  parameter int INIT_ONEHOT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rd_req,
  input  logic [ADDR_W-1:0]      rd_addr1,
  input  logic [ADDR_W-1:0]      rd_addr2,
  output logic [DATA_W-1:0]      rd_data1,
  output logic [DATA_W-1:0]      rd_data2,
  output logic                   rd_valid,
  output logic                   rd_stall,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic [(2**ADDR_W)-1:0] busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] rst_val [DEPTH];
  logic [DATA_W-1:0] rd_nxt1;
  logic [DATA_W-1:0] rd_nxt2;
  logic              wr_ok;
  logic              rd_accept;

  reg_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_req   (rd_req),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .busy     (busy),
    .rd_stall (rd_stall)
  );

  // Per-entry reset image (one-hot or zero), constant after elaboration.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int b = 0; b < DATA_W; b++) begin
        rst_val[i][b] = rst_bit(INIT_ONEHOT, i, b, DATA_W);
      end
    end
  end

  // Hardwired-zero entry 0 swallows writes; reads accepted only when not stalled.
  always_comb begin
    wr_ok     = wr_en && !((ZERO_R0 != 0) && (wr_addr == '0));
    rd_accept = rd_req && !rd_stall;
  end

  // Read mux with write-first bypass; hardwired entry 0 overrides everything.
  always_comb begin
    rd_nxt1 = mem[rd_addr1];
    rd_nxt2 = mem[rd_addr2];
    if (wr_en && (wr_addr == rd_addr1)) rd_nxt1 = wr_data;
    if (wr_en && (wr_addr == rd_addr2)) rd_nxt2 = wr_data;
    if ((ZERO_R0 != 0) && (rd_addr1 == '0)) rd_nxt1 = '0;
    if ((ZERO_R0 != 0) && (rd_addr2 == '0)) rd_nxt2 = '0;
  end

  // Storage: reset loads the init image, otherwise a single write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= rst_val[i];
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read outputs; data holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data1 <= '0;
      rd_data2 <= '0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        rd_data1 <= rd_nxt1;
        rd_data2 <= rd_nxt2;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios then randomized traffic vs a reference model.
// Latency: checks outputs 1 ns after each rising edge, rd_stall before the edge.
// Backpressure: model predicts rd_stall and held data on refused reads.
module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;

  logic        rd_req, wr_en, rsv_en;
  logic [2:0]  rd_addr1, rd_addr2, wr_addr, rsv_addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data1, rd_data2;
  logic        rd_valid, rd_stall;
  logic [7:0]  busy;

  logic        z_rd_req, z_wr_en, z_rsv_en;
  logic [2:0]  z_rd_addr1, z_rd_addr2, z_wr_addr, z_rsv_addr;
  logic [15:0] z_wr_data;
  logic [15:0] z_rd_data1, z_rd_data2;
  logic        z_rd_valid, z_rd_stall;
  logic [7:0]  z_busy;

  int checks = 0;
  int errors = 0;

  // Reference model state; index 0 = default DUT, 1 = hardwired-zero DUT.
  logic [15:0] m_mem  [2][8];
  logic        m_busy [2][8];
  logic        m_vld  [2];
  logic [15:0] m_d1   [2];
  logic [15:0] m_d2   [2];

  reg_file_sb dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_valid(rd_valid), .rd_stall(rd_stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy)
  );

  reg_file_sb #(.ZERO_R0(1)) dut_z (
    .clk(clk), .rst_n(rst_n),
    .rd_req(z_rd_req), .rd_addr1(z_rd_addr1), .rd_addr2(z_rd_addr2),
    .rd_data1(z_rd_data1), .rd_data2(z_rd_data2),
    .rd_valid(z_rd_valid), .rd_stall(z_rd_stall),
    .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data),
    .rsv_en(z_rsv_en), .rsv_addr(z_rsv_addr), .busy(z_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] mbusy(input int k);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_busy[k][i];
    return v;
  endfunction

  function automatic logic mstall(input int k, input logic rq, input logic [2:0] a1, a2,
                                  input logic we, input logic [2:0] wa);
    logic s1, s2;
    s1 = m_busy[k][a1] && !(we && wa == a1);
    s2 = m_busy[k][a2] && !(we && wa == a2);
    return rq && (s1 || s2);
  endfunction

  function automatic logic [15:0] mlook(input int k, input logic [2:0] a, input logic we,
                                        input logic [2:0] wa, input logic [15:0] wd);
    if (k == 1 && a == 3'd0) return 16'h0000;
    if (we && wa == a) return wd;
    return m_mem[k][a];
  endfunction

  task automatic model_step(input int k, input logic rst, input logic rq,
                            input logic [2:0] a1, a2, input logic we, input logic [2:0] wa,
                            input logic [15:0] wd, input logic rs, input logic [2:0] ra);
    logic st;
    st = mstall(k, rq, a1, a2, we, wa);
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        m_mem[k][i]  = 16'h0001 << (i % 16);
        m_busy[k][i] = 1'b0;
      end
      m_vld[k] = 1'b0;
      m_d1[k]  = 16'h0000;
      m_d2[k]  = 16'h0000;
    end else begin
      m_vld[k] = rq && !st;
      if (m_vld[k]) begin
        m_d1[k] = mlook(k, a1, we, wa, wd);
        m_d2[k] = mlook(k, a2, we, wa, wd);
      end
      if (we && !(k == 1 && wa == 3'd0)) m_mem[k][wa] = wd;
      if (we) m_busy[k][wa] = 1'b0;
      if (rs && !(k == 1 && ra == 3'd0)) m_busy[k][ra] = 1'b1;
    end
  endtask

  // One clock cycle: inputs are already driven (called just after a falling edge).
  task automatic tick();
    #1;
    chk("stall", 32'(rd_stall), 32'(mstall(0, rd_req, rd_addr1, rd_addr2, wr_en, wr_addr)));
    chk("z_stall", 32'(z_rd_stall),
        32'(mstall(1, z_rd_req, z_rd_addr1, z_rd_addr2, z_wr_en, z_wr_addr)));
    model_step(0, rst_n, rd_req, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr);
    model_step(1, rst_n, z_rd_req, z_rd_addr1, z_rd_addr2, z_wr_en, z_wr_addr, z_wr_data,
               z_rsv_en, z_rsv_addr);
    @(posedge clk);
    #1;
    chk("valid", 32'(rd_valid), 32'(m_vld[0]));
    chk("data1", 32'(rd_data1), 32'(m_d1[0]));
    chk("data2", 32'(rd_data2), 32'(m_d2[0]));
    chk("busy",  32'(busy), 32'(mbusy(0)));
    chk("z_valid", 32'(z_rd_valid), 32'(m_vld[1]));
    chk("z_data1", 32'(z_rd_data1), 32'(m_d1[1]));
    chk("z_data2", 32'(z_rd_data2), 32'(m_d2[1]));
    chk("z_busy",  32'(z_busy), 32'(mbusy(1)));
    @(negedge clk);
  endtask

  task automatic idle();
    rd_req = 0; rd_addr1 = 0; rd_addr2 = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    rsv_en = 0; rsv_addr = 0;
    z_rd_req = 0; z_rd_addr1 = 0; z_rd_addr2 = 0; z_wr_en = 0; z_wr_addr = 0;
    z_wr_data = 0; z_rsv_en = 0; z_rsv_addr = 0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        m_mem[k][i] = 16'h0000;
        m_busy[k][i] = 1'b0;
      end
      m_vld[k] = 1'b0; m_d1[k] = 16'h0000; m_d2[k] = 16'h0000;
    end
    idle();
    rst_n = 1'b0;
    @(negedge clk);

    // Reset with traffic present: reset must dominate.
    wr_en = 1; wr_addr = 3'd3; wr_data = 16'h7777; rsv_en = 1; rsv_addr = 3'd2; rd_req = 1;
    tick();
    idle();
    tick();
    chk("rst_valid", 32'(rd_valid), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_data1", 32'(rd_data1), 32'h0);
    rst_n = 1'b1;

    // Reset image read back on both ports.
    rd_req = 1; rd_addr1 = 3'd3; rd_addr2 = 3'd7;
    tick();
    chk("init_valid", 32'(rd_valid), 32'h1);
    chk("init_d1", 32'(rd_data1), 32'h0008);
    chk("init_d2", 32'(rd_data2), 32'h0080);

    // Write-first bypass, both ports on the same address.
    idle();
    wr_en = 1; wr_addr = 3'd5; wr_data = 16'hBEEF; rd_req = 1; rd_addr1 = 3'd5; rd_addr2 = 3'd5;
    tick();
    chk("bypass_d1", 32'(rd_data1), 32'hBEEF);
    chk("bypass_d2", 32'(rd_data2), 32'hBEEF);

    // Reserve 2, refused read, then release-by-write with retried read.
    idle();
    rsv_en = 1; rsv_addr = 3'd2;
    tick();
    idle();
    rd_req = 1; rd_addr1 = 3'd2; rd_addr2 = 3'd2;
    #1 chk("rsv_stall", 32'(rd_stall), 32'h1);
    tick();
    chk("refused_valid", 32'(rd_valid), 32'h0);
    chk("refused_hold", 32'(rd_data1), 32'hBEEF);
    wr_en = 1; wr_addr = 3'd2; wr_data = 16'h1234;
    #1 chk("release_stall", 32'(rd_stall), 32'h0);
    tick();
    chk("release_d1", 32'(rd_data1), 32'h1234);
    chk("release_busy2", 32'(busy[2]), 32'h0);

    // Reserve and write the same entry: set wins, data written.
    idle();
    rsv_en = 1; rsv_addr = 3'd4; wr_en = 1; wr_addr = 3'd4; wr_data = 16'hABCD;
    tick();
    chk("setwin_busy4", 32'(busy[4]), 32'h1);
    chk("setwin_mem4", 32'(dut.mem[4]), 32'hABCD);

    // Back-to-back accepted reads.
    idle();
    rd_req = 1; rd_addr1 = 3'd1; rd_addr2 = 3'd3;
    tick();
    chk("b2b_valid0", 32'(rd_valid), 32'h1);
    rd_addr1 = 3'd0; rd_addr2 = 3'd7;
    tick();
    chk("b2b_valid1", 32'(rd_valid), 32'h1);
    chk("b2b_d1", 32'(rd_data1), 32'h0001);

    // Reset drops an in-flight read and restores the init image.
    idle();
    wr_en = 1; wr_addr = 3'd6; wr_data = 16'h5555; rsv_en = 1; rsv_addr = 3'd1;
    tick();
    idle();
    rst_n = 0; rd_req = 1; rd_addr1 = 3'd1; rd_addr2 = 3'd6;
    wr_en = 1; wr_addr = 3'd3; wr_data = 16'hFFFF; rsv_en = 1; rsv_addr = 3'd5;
    #1 chk("rst_stall_busy1", 32'(rd_stall), 32'h1);
    tick();
    chk("rst2_busy", 32'(busy), 32'h0);
    chk("rst2_valid", 32'(rd_valid), 32'h0);
    chk("rst2_mem6", 32'(dut.mem[6]), 32'h0040);
    chk("rst2_mem3", 32'(dut.mem[3]), 32'h0008);
    rst_n = 1;
    idle();

    // Hardwired-zero entry: write and reserve ignored, reads return 0, no stall.
    z_wr_en = 1; z_wr_addr = 3'd0; z_wr_data = 16'hFFFF; z_rsv_en = 1; z_rsv_addr = 3'd0;
    z_rd_req = 1; z_rd_addr1 = 3'd0; z_rd_addr2 = 3'd0;
    #1 chk("z0_stall_a", 32'(z_rd_stall), 32'h0);
    tick();
    chk("z0_busy0", 32'(z_busy[0]), 32'h0);
    chk("z0_d1_a", 32'(z_rd_data1), 32'h0);
    chk("z0_valid", 32'(z_rd_valid), 32'h1);
    idle();
    z_rd_req = 1; z_rd_addr1 = 3'd0; z_rd_addr2 = 3'd1;
    tick();
    chk("z0_d1_b", 32'(z_rd_data1), 32'h0);
    chk("z0_d2_b", 32'(z_rd_data2), 32'h0002);

    // Randomized traffic on both instances against the model.
    for (int n = 0; n < 400; n++) begin
      rst_n      = ($urandom_range(63) != 0);
      rd_req     = $urandom_range(1);
      rd_addr1   = 3'($urandom_range(7));
      rd_addr2   = 3'($urandom_range(7));
      wr_en      = $urandom_range(1);
      wr_addr    = 3'($urandom_range(7));
      wr_data    = 16'($urandom);
      rsv_en     = ($urandom_range(3) == 0);
      rsv_addr   = 3'($urandom_range(7));
      z_rd_req   = $urandom_range(1);
      z_rd_addr1 = 3'($urandom_range(3));
      z_rd_addr2 = 3'($urandom_range(7));
      z_wr_en    = $urandom_range(1);
      z_wr_addr  = 3'($urandom_range(3));
      z_wr_data  = 16'($urandom);
      z_rsv_en   = ($urandom_range(3) == 0);
      z_rsv_addr = 3'($urandom_range(3));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 16: register width in bits.
REQ-002 Parameter ADDR_W, default 3: address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_R0, default 0: 1 makes entry 0 read as zero, ignore writes and ignore reservations.
REQ-004 Parameter INIT_ONEHOT, default 1: 1 gives entry i the reset value 1 << (i mod DATA_W); 0 gives all-zero reset values.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset; synchronous, active-low.
REQ-007 rd_req  in  1  read request for both read ports.
REQ-008 rd_addr1, rd_addr2  in  ADDR_W  read addresses.
REQ-009 rd_data1, rd_data2  out  DATA_W  registered read data.
REQ-010 rd_valid  out  1  rd_data1/rd_data2 valid this cycle.
REQ-011 rd_stall  out  1  combinational; the current rd_req is refused.
REQ-012 wr_en  in  1  high-level write enable.
REQ-013 wr_addr  in  ADDR_W  write address.
REQ-014 wr_data  in  DATA_W  write data.
REQ-015 rsv_en  in  1  reserve: mark entry rsv_addr as having a pending producer.
REQ-016 rsv_addr  in  ADDR_W  address to reserve.
REQ-017 busy  out  DEPTH  per-entry busy bits (scoreboard), registered.

Function
REQ-018 Write: when wr_en=1 at the rising edge, mem[wr_addr] SHALL take wr_data; ignored for entry 0 when ZERO_R0=1.
REQ-019 Write release: a write SHALL clear busy[wr_addr] at the same edge.
REQ-020 Reserve: rsv_en=1 SHALL set busy[rsv_addr] at the edge.
REQ-021 Reserve and write to the same address in one cycle: the set SHALL win (busy stays 1) and the data SHALL still be written.
REQ-022 Reserve an already-busy entry: no change; no error flagged.
REQ-023 rd_stall SHALL be 1 iff rd_req=1 and, for either read address a, busy[a]=1 and NOT (wr_en=1 and wr_addr=a).
REQ-024 Accepted read: when rd_req=1 and rd_stall=0, the next cycle SHALL have rd_valid=1 and rd_dataN = mem[rd_addrN] (1-cycle latency).
REQ-025 Bypass: same-cycle wr_en to the read address SHALL make the read return wr_data (write-first).
REQ-026 Entry 0 with ZERO_R0=1 SHALL always read 0 and never stall.
REQ-027 Refused or absent read: rd_valid SHALL be 0 next cycle, and rd_data1/rd_data2 SHALL hold their previous values.
REQ-028 Both read ports to the same address SHALL return identical data.
REQ-029 Back-to-back accepted reads SHALL give rd_valid=1 on consecutive cycles (full throughput).

Reset
REQ-030 With rst_n=0 at the edge: mem SHALL take its INIT_ONEHOT values, busy=0, rd_valid=0, rd_data1=rd_data2=0.
REQ-031 Reset SHALL take priority over simultaneous wr_en, rsv_en and rd_req; a read in flight SHALL be dropped (rd_valid=0 after reset).
REQ-032 rd_stall SHALL follow REQ-023 during reset using the current busy bits; outputs are valid from the first edge after rst_n rises.

Structure
REQ-033 Shared package SHALL hold DATA_W/ADDR_W defaults and the reset-value function (one-hot/zero).
REQ-034 The scoreboard (busy bits, set/clear priority, stall compare) SHALL be one sub-module, reg_scoreboard; storage and read path SHALL stay in reg_file_sb.

Verification (defaults, INIT_ONEHOT=1)
REQ-035 Reset, then read 3 and 7 -> next cycle rd_valid=1, rd_data1=16'h0008, rd_data2=16'h0080.
REQ-036 Write 16'hBEEF to 5 while reading 5 in the same cycle -> next cycle rd_data1=16'hBEEF (bypass).
REQ-037 Reserve 2; next cycle read 2 -> rd_stall=1, rd_valid=0 next cycle, data held; write 16'h1234 to 2 with the read retried in the same cycle -> no stall, returns 16'h1234, busy[2]=0.
REQ-038 Reserve 4 and write 4 in the same cycle -> busy[4]=1 and mem[4]=written data.
REQ-039 ZERO_R0=1: write 16'hFFFF to 0, reserve 0, read 0 -> returns 0, never stalls, busy[0]=0.
REQ-040 Write 6 and reserve 1, then assert rst_n=0 with rd_req=1 -> busy=0, rd_valid=0, and mem[6]=16'h0040 afterwards.
